// File: rtl/accum_table_rd_control_pkg.sv
// Shared types and sizing helpers for the accumulator table read sequencer.
// Default geometry and the derived sizes live here so every file agrees.
package accum_table_rd_control_pkg;

  localparam int DEF_MAX_OUT_ROWS  = 128;
  localparam int DEF_MAX_OUT_COLS  = 128;
  localparam int DEF_SYS_ARR_ROWS  = 16;
  localparam int DEF_SYS_ARR_COLS  = 16;
  localparam int DEF_NUM_SUBMATS_M =
    DEF_MAX_OUT_ROWS / DEF_SYS_ARR_ROWS;
  localparam int DEF_NUM_SUBMATS_N =
    DEF_MAX_OUT_COLS / DEF_SYS_ARR_COLS;
  localparam int DEF_ADDR_WIDTH =
    $clog2(DEF_MAX_OUT_ROWS * DEF_NUM_SUBMATS_N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Index fields never shrink below one bit, even for a 1-entry range.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/accumTableAddr_control.sv
// Row/sub-matrix indices to accumulator table address.
// Shared by the write and read sides so both use one mapping.
module accumTableAddr_control
  import accum_table_rd_control_pkg::*;
#(
  parameter int MAX_OUT_ROWS = DEF_MAX_OUT_ROWS,
  parameter int SYS_ARR_ROWS = DEF_SYS_ARR_ROWS,
  parameter int RW           = 4,
  parameter int MW           = 3,
  parameter int NW           = 3,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH
) (
  input  logic [RW-1:0]         sub_row,
  input  logic [MW-1:0]         submat_m,
  input  logic [NW-1:0]         submat_n,
  output logic [ADDR_WIDTH-1:0] addr
);

  int sum;

  always_comb begin
    sum = int'(submat_n) * MAX_OUT_ROWS
        + int'(submat_m) * SYS_ARR_ROWS
        + int'(sub_row);
    addr = ADDR_WIDTH'(sum);
  end

endmodule

// File: rtl/accum_table_rd_control.sv
// Read-side sequencer: walks the output region one row per cycle,
// tags returned rows and optionally clears them as they come back.
module accum_table_rd_control
  import accum_table_rd_control_pkg::*;
#(
  parameter int MAX_OUT_ROWS = DEF_MAX_OUT_ROWS,
  parameter int MAX_OUT_COLS = DEF_MAX_OUT_COLS,
  parameter int SYS_ARR_ROWS = DEF_SYS_ARR_ROWS,
  parameter int SYS_ARR_COLS = DEF_SYS_ARR_COLS,
  localparam int NUM_SUBMATS_M = MAX_OUT_ROWS / SYS_ARR_ROWS,
  localparam int NUM_SUBMATS_N = MAX_OUT_COLS / SYS_ARR_COLS,
  localparam int ADDR_WIDTH =
    $clog2(MAX_OUT_ROWS * NUM_SUBMATS_N),
  localparam int RW = idx_w(SYS_ARR_ROWS),
  localparam int MW = idx_w(NUM_SUBMATS_M),
  localparam int NW = idx_w(NUM_SUBMATS_N),
  localparam int AW = ADDR_WIDTH * SYS_ARR_COLS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [MW-1:0]           submat_m_last,
  input  logic [NW-1:0]           submat_n_last,
  input  logic                    clear,
  input  logic                    out_ready,
  output logic [SYS_ARR_COLS-1:0] rd_en_out,
  output logic [AW-1:0]           rd_addr_out,
  output logic                    data_valid,
  output logic [RW-1:0]           data_sub_row,
  output logic [MW-1:0]           data_submat_m,
  output logic [NW-1:0]           data_submat_n,
  output logic [SYS_ARR_COLS-1:0] clr_en_out,
  output logic [AW-1:0]           clr_addr_out,
  output logic                    busy,
  output logic                    done
);

  state_e                state_q;
  logic [RW-1:0]         row_q, row_d;
  logic [MW-1:0]         m_q, m_d, m_last_q;
  logic [NW-1:0]         n_q, n_d, n_last_q;
  logic                  clear_q;
  logic [ADDR_WIDTH-1:0] addr, addr_q;
  logic                  issue;
  logic                  row_wrap, m_wrap, n_wrap;

  assign issue    = (state_q == READ) && out_ready;
  assign row_wrap = row_q == RW'(SYS_ARR_ROWS - 1);
  assign m_wrap   = m_q == m_last_q;
  assign n_wrap   = n_q == n_last_q;

  accumTableAddr_control #(
    .MAX_OUT_ROWS (MAX_OUT_ROWS),
    .SYS_ARR_ROWS (SYS_ARR_ROWS),
    .RW           (RW),
    .MW           (MW),
    .NW           (NW),
    .ADDR_WIDTH   (ADDR_WIDTH)
  ) u_addr (
    .sub_row  (row_q),
    .submat_m (m_q),
    .submat_n (n_q),
    .addr     (addr)
  );

  assign rd_en_out    = {SYS_ARR_COLS{issue}};
  assign rd_addr_out  = {SYS_ARR_COLS{addr}};
  assign clr_en_out   = {SYS_ARR_COLS{data_valid && clear_q}};
  assign clr_addr_out = {SYS_ARR_COLS{addr_q}};

  // sub_row is innermost, then m, then n
  always_comb begin
    row_d = row_q;
    m_d   = m_q;
    n_d   = n_q;
    if (issue) begin
      row_d = row_wrap ? '0 : row_q + RW'(1);
      if (row_wrap) begin
        m_d = m_wrap ? '0 : m_q + MW'(1);
        if (m_wrap) n_d = n_wrap ? '0 : n_q + NW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      row_q         <= '0;
      m_q           <= '0;
      n_q           <= '0;
      m_last_q      <= '0;
      n_last_q      <= '0;
      clear_q       <= 1'b0;
      addr_q        <= '0;
      data_valid    <= 1'b0;
      data_sub_row  <= '0;
      data_submat_m <= '0;
      data_submat_n <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      data_valid    <= issue;
      data_sub_row  <= row_q;
      data_submat_m <= m_q;
      data_submat_n <= n_q;
      addr_q        <= addr;
      done          <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= READ;
            m_last_q <= submat_m_last;
            n_last_q <= submat_n_last;
            clear_q  <= clear;
            row_q    <= '0;
            m_q      <= '0;
            n_q      <= '0;
            busy     <= 1'b1;
          end
        end
        READ: begin
          row_q <= row_d;
          m_q   <= m_d;
          n_q   <= n_d;
          if (issue && row_wrap && m_wrap && n_wrap)
            state_q <= DRAIN;
        end
        DRAIN: begin
          state_q <= DONE;
          done    <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          busy    <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accum_table_rd_control.sv
// Randomized directed bench for accum_table_rd_control (8x8 out, 4x4 array).
// Expected rows come from a plain nested-loop list of the output region.
module tb_accum_table_rd_control;

  localparam int MOR = 8;
  localparam int MOC = 8;
  localparam int SAR = 4;
  localparam int SAC = 4;
  localparam int AWD = 4;

  logic        clk = 1'b0;
  logic        reset, start, clear, out_ready;
  logic [0:0]  m_last, n_last;
  logic [3:0]  rd_en, clr_en;
  logic [15:0] rd_addr, clr_addr;
  logic        dv, busy, done;
  logic [1:0]  t_row;
  logic [0:0]  t_m, t_n;

  int checks = 0;
  int errors = 0;
  int dcyc;

  always #5 clk = ~clk;

  accum_table_rd_control #(
    .MAX_OUT_ROWS (MOR),
    .MAX_OUT_COLS (MOC),
    .SYS_ARR_ROWS (SAR),
    .SYS_ARR_COLS (SAC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .submat_m_last (m_last),
    .submat_n_last (n_last),
    .clear         (clear),
    .out_ready     (out_ready),
    .rd_en_out     (rd_en),
    .rd_addr_out   (rd_addr),
    .data_valid    (dv),
    .data_sub_row  (t_row),
    .data_submat_m (t_m),
    .data_submat_n (t_n),
    .clr_en_out    (clr_en),
    .clr_addr_out  (clr_addr),
    .busy          (busy),
    .done          (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rep(input int a);
    logic [3:0] v;
    v = 4'(a);
    return {4{v}};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_side();
    m_last = 1'($urandom);
    n_last = 1'($urandom);
    clear  = 1'($urandom);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_en"}, 32'(rd_en), 0);
    chk({tag, "_rd_addr"}, 32'(rd_addr), 0);
    chk({tag, "_dv"}, 32'(dv), 0);
    chk({tag, "_tags"}, 32'({t_row, t_m, t_n}), 0);
    chk({tag, "_clr_en"}, 32'(clr_en), 0);
    chk({tag, "_clr_addr"}, 32'(clr_addr), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
  endtask

  // rmode: 0 ready high, 1 ready low in cycles 2-3, 2 random
  // intf:  0 none, 1 extra start in cycle 3, 2 reset in cycle 3
  task automatic run(input int ml, input int nl, input bit clr,
                     input int rmode, input int intf,
                     output int done_cyc);
    int ea[$], es[$], em[$], en[$];
    int idx, last_c, p_a, p_s, p_m, p_n;
    bit p_iss, exp_rd, fin;
    for (int n = 0; n <= nl; n++)
      for (int m = 0; m <= ml; m++)
        for (int s = 0; s < SAR; s++) begin
          ea.push_back(n * MOR + m * SAR + s);
          es.push_back(s);
          em.push_back(m);
          en.push_back(n);
        end
    idx = 0; last_c = -1; p_iss = 0; fin = 0;
    p_a = 0; p_s = 0; p_m = 0; p_n = 0;
    done_cyc = -1;

    next_cycle();
    reset = 1; start = 1;
    m_last = 1'(ml); n_last = 1'(nl); clear = clr;
    out_ready = 1'($urandom);
    #3;
    chk("c0_rd_en", 32'(rd_en), 0);
    chk("c0_busy", 32'(busy), 0);
    chk("c0_dv", 32'(dv), 0);

    for (int c = 1; c < 200; c++) begin
      next_cycle();
      start = 0;
      rand_side();
      case (rmode)
        0:       out_ready = 1;
        1:       out_ready = !(c == 2 || c == 3);
        default: out_ready = ($urandom_range(3) != 0);
      endcase
      reset = !(intf == 2 && c == 3);
      if (intf == 1 && c == 3) start = 1;
      #3;
      if (intf == 2 && c == 4) begin
        chk_all_zero("after_rst");
        fin = 1;
        break;
      end
      exp_rd = (idx < ea.size()) && out_ready;
      chk("rd_en", 32'(rd_en), exp_rd ? 32'hF : 0);
      if (exp_rd) chk("rd_addr", 32'(rd_addr), 32'(rep(ea[idx])));
      chk("dv", 32'(dv), 32'(p_iss));
      if (p_iss) begin
        chk("tag_row", 32'(t_row), 32'(p_s));
        chk("tag_m", 32'(t_m), 32'(p_m));
        chk("tag_n", 32'(t_n), 32'(p_n));
        chk("clr_addr", 32'(clr_addr), 32'(rep(p_a)));
      end
      chk("clr_en", 32'(clr_en), (p_iss && clr) ? 32'hF : 0);
      chk("done", 32'(done),
          32'(last_c >= 0 && c == last_c + 2));
      chk("busy", 32'(busy),
          32'(last_c < 0 || c <= last_c + 2));
      if (done === 1'b1 && done_cyc < 0) done_cyc = c;
      if (last_c >= 0 && c == last_c + 3) begin
        fin = 1;
        break;
      end
      p_iss = exp_rd;
      if (exp_rd) begin
        p_a = ea[idx]; p_s = es[idx];
        p_m = em[idx]; p_n = en[idx];
        idx++;
        if (idx == ea.size()) last_c = c;
      end
    end
    if (!fin) begin
      checks++;
      errors++;
      $error("FAIL timeout observed=%0d expected=%0d", idx, ea.size());
    end
  endtask

  initial begin
    reset = 0; start = 0; out_ready = 0;
    m_last = 0; n_last = 0; clear = 0;
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      start = 1'($urandom);
      out_ready = 1'($urandom);
      rand_side();
      #3;
      chk_all_zero("reset");
    end
    next_cycle();
    reset = 1; start = 0;

    run(0, 0, 0, 0, 0, dcyc);
    chk("done_cyc_1x1", 32'(dcyc), 6);
    run(1, 1, 0, 0, 0, dcyc);
    chk("done_cyc_2x2", 32'(dcyc), 18);
    run(0, 0, 0, 1, 0, dcyc);
    chk("done_cyc_bp", 32'(dcyc), 8);
    run(0, 0, 1, 0, 0, dcyc);
    chk("done_cyc_clr", 32'(dcyc), 6);
    run(0, 0, 0, 0, 1, dcyc);
    chk("done_cyc_restart", 32'(dcyc), 6);
    run(1, 1, 1, 0, 2, dcyc);
    chk("done_cyc_rst", 32'(dcyc), 32'(-1));
    run(0, 0, 0, 0, 0, dcyc);
    chk("done_cyc_after_rst", 32'(dcyc), 6);
    for (int k = 0; k < 20; k++)
      run(int'($urandom_range(1)), int'($urandom_range(1)),
          1'($urandom), 2, int'($urandom_range(1)), dcyc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
